// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
interface uart_tx_buffered_if;
   logic [7:0] data;
   logic       dataValid;
   logic       dataReady;

   modport master (
      output data,
      output dataValid,
      input  dataReady
   );

   modport slave (
      input  data,
      input  dataValid,
      output dataReady
   );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter with a byte FIFO and internal baud timing.
// Define UART_TX_PARITY_EN to send an even-parity bit (8E1 frames).
module uart_tx_buffered #(
   parameter int CLOCK_RATE = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic clk,
   input  logic reset,
   uart_tx_buffered_if.slave bus,
   output logic txd,
   output logic busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifoCount
);
   localparam int DIVIDER = CLOCK_RATE / BAUD_RATE;
   localparam int CW = $clog2(DIVIDER);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);
   localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_n;
   logic [7:0] shift, shift_n;
   logic line, line_n;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] count, count_n;
   logic [7:0] mem [FIFO_DEPTH];
   logic push, pop, bit_end, ready;
`ifdef UART_TX_PARITY_EN
   logic par, par_n;
`endif

   assign ready = count < COUNT_FULL;
   assign bus.dataReady = ready;
   assign push = bus.dataValid && ready;
   assign bit_end = cnt == CNT_LAST;
   assign txd = line;
   assign fifoCount = count;
   assign busy = (state != IDLE) || (count != '0);

   always_comb begin
      state_n = state;
      cnt_n = bit_end ? '0 : cnt + 1'b1;
      bit_n = bit_idx;
      shift_n = shift;
      pop = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n = par;
`endif
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (count != '0) begin
               pop = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) state_n = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_n = shift >> 1;
               bit_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_n = STOP;
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (count != '0) begin
                  pop = 1'b1;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
      endcase

      // a pop always starts a fresh frame from the head byte
      if (pop) begin
         shift_n = mem[rd_ptr];
         bit_n = '0;
         cnt_n = '0;
`ifdef UART_TX_PARITY_EN
         par_n = ^mem[rd_ptr];
`endif
      end

      // line level is registered from the state being entered
      case (state_n)
         START: line_n = 1'b0;
         DATA: line_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
         PARITY: line_n = par_n;
`endif
         default: line_n = 1'b1;
      endcase

      case ({push, pop})
         2'b10: count_n = count + NW'(1);
         2'b01: count_n = count - NW'(1);
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         line <= 1'b1;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
`ifdef UART_TX_PARITY_EN
         par <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         shift <= shift_n;
         line <= line_n;
         count <= count_n;
`ifdef UART_TX_PARITY_EN
         par <= par_n;
`endif
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.data;
   end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered against a frame-timeline model.
// Frames start at max(accept edge + 1, previous frame start + frame length).
module tb_uart_tx_buffered;
   localparam int DIV = 10;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int L = NBITS * DIV;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic txd;
   logic busy;
   logic [2:0] fifoCount;

   uart_tx_buffered_if bus();

   uart_tx_buffered #(
      .CLOCK_RATE(100),
      .BAUD_RATE(10),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .txd(txd),
      .busy(busy),
      .fifoCount(fifoCount)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   int n_checks = 0;
   int n_fail = 0;
   int acc_edge[$];
   int starts[$];
   logic [7:0] acc_byte[$];
   logic [7:0] pend[$];

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic int exp_count(input int e);
      int c = 0;
      foreach (acc_edge[i]) if (acc_edge[i] <= e) c++;
      foreach (starts[i]) if (starts[i] <= e) c--;
      return c;
   endfunction

   function automatic logic exp_txd(input int e);
      foreach (starts[i])
         if (e >= starts[i] && e < starts[i] + L)
            return frame_bit(acc_byte[i], (e - starts[i]) / DIV);
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int e);
      if (exp_count(e) != 0) return 1'b1;
      foreach (starts[i])
         if (e >= starts[i] && e < starts[i] + L) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step(input logic rst_in);
      int s;
      reset = rst_in;
      bus.dataValid = !rst_in && pend.size() != 0;
      if (bus.dataValid) bus.data = pend[0];
      @(posedge clk);
      edge_n++;
      if (rst_in) begin
         acc_edge.delete();
         acc_byte.delete();
         starts.delete();
         pend.delete();
      end else if (bus.dataValid && exp_count(edge_n - 1) < DEPTH) begin
         s = edge_n + 1;
         if (starts.size() != 0 && starts[$] + L > s) s = starts[$] + L;
         acc_edge.push_back(edge_n);
         acc_byte.push_back(pend.pop_front());
         starts.push_back(s);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      bus.data = 8'h00;
      bus.dataValid = 1'b0;
      step(1);
      step(1);
      n_checks += 4;
      if (txd !== 1'b1) begin
         n_fail++; $display("FAIL reset_txd got %b want 1", txd);
      end
      if (bus.dataReady !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got %b want 1", bus.dataReady);
      end
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %b want 0", busy);
      end
      if (fifoCount !== 3'd0) begin
         n_fail++; $display("FAIL reset_count got %0d want 0", fifoCount);
      end
      step(0);
   endtask

   task automatic test_single;
      int k;
      int idx;
      logic [9:0] a5_line;
      a5_line = 10'b1101001010;
      pend.push_back(8'hA5);
      step(0);
      k = edge_n;
      while (edge_n <= k + L + 3) begin
         n_checks += 3;
         if (txd !== exp_txd(edge_n)) begin
            n_fail++; $display("FAIL single_txd edge %0d got %b want %b", edge_n, txd, exp_txd(edge_n));
         end
         if (busy !== exp_busy(edge_n)) begin
            n_fail++; $display("FAIL single_busy edge %0d got %b want %b", edge_n, busy, exp_busy(edge_n));
         end
         if (fifoCount !== 3'(exp_count(edge_n))) begin
            n_fail++; $display("FAIL single_count edge %0d got %0d want %0d", edge_n, fifoCount, exp_count(edge_n));
         end
         if (edge_n == k + 1) begin
            n_checks++;
            if (txd !== 1'b0) begin
               n_fail++; $display("FAIL single_fall got %b want 0", txd);
            end
         end
         if (edge_n == k + L + 1) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++; $display("FAIL single_busy_drop got %b want 0", busy);
            end
         end
         idx = (edge_n - k - 1) / DIV;
         if (edge_n > k && (edge_n - k - 1) % DIV == 5 && idx < 10) begin
            n_checks++;
`ifdef UART_TX_PARITY_EN
            if (txd !== frame_bit(8'hA5, idx)) begin
               n_fail++; $display("FAIL single_bit%0d got %b want %b", idx, txd, frame_bit(8'hA5, idx));
            end
`else
            if (txd !== a5_line[idx]) begin
               n_fail++; $display("FAIL single_bit%0d got %b want %b", idx, txd, a5_line[idx]);
            end
`endif
         end
         step(0);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      int k;
      pend.push_back(8'h07);
      step(0);
      k = edge_n;
      while (edge_n <= k + 112) begin
         if (edge_n == k + 96) begin
            n_checks++;
            if (txd !== 1'b1) begin
               n_fail++; $display("FAIL parity_bit got %b want 1", txd);
            end
         end
         if (edge_n == k + 110) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++; $display("FAIL parity_len_busy got %b want 1", busy);
            end
         end
         if (edge_n == k + 111) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++; $display("FAIL parity_len_idle got %b want 0", busy);
            end
         end
         step(0);
      end
   endtask
`endif

   task automatic test_back_to_back;
      int k;
      logic [2:0] want;
      pend.push_back(8'h11);
      pend.push_back(8'h22);
      pend.push_back(8'h33);
      step(0);
      k = edge_n;
      while (edge_n <= k + 3 * L + 2) begin
         n_checks++;
         if (txd !== exp_txd(edge_n)) begin
            n_fail++; $display("FAIL b2b_txd edge %0d got %b want %b", edge_n, txd, exp_txd(edge_n));
         end
         if (edge_n <= k + 2) begin
            want = (edge_n == k + 2) ? 3'd2 : 3'd1;
            n_checks++;
            if (fifoCount !== want) begin
               n_fail++; $display("FAIL b2b_count edge +%0d got %0d want %0d", edge_n - k, fifoCount, want);
            end
         end
         if (edge_n == k + 2 * L || edge_n == k + 2 * L + 1) begin
            want = (edge_n == k + 2 * L) ? 3'd1 : 3'd0;
            n_checks++;
            if (fifoCount !== want) begin
               n_fail++; $display("FAIL b2b_last_pop edge +%0d got %0d want %0d", edge_n - k, fifoCount, want);
            end
         end
         if (edge_n == k + 1 + L || edge_n == k + 1 + 2 * L) begin
            n_checks++;
            if (txd !== 1'b0) begin
               n_fail++; $display("FAIL b2b_gap edge +%0d got %b want 0", edge_n - k, txd);
            end
         end
         step(0);
      end
   endtask

   task automatic test_overflow;
      logic [7:0] sent [6];
      logic [7:0] rx [6];
      int base;
      int r;
      int guard;
      int max_cnt;
      int rel;
      r = $urandom_range(0, 255);
      base = acc_byte.size();
      max_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         sent[i] = 8'(r + i * 41);
         rx[i] = 8'h00;
         pend.push_back(sent[i]);
      end
      guard = 0;
      while ((pend.size() != 0 || exp_busy(edge_n)) && guard < 2000) begin
         step(0);
         guard++;
         n_checks += 3;
         if (txd !== exp_txd(edge_n)) begin
            n_fail++; $display("FAIL ovf_txd edge %0d got %b want %b", edge_n, txd, exp_txd(edge_n));
         end
         if (fifoCount !== 3'(exp_count(edge_n))) begin
            n_fail++; $display("FAIL ovf_count edge %0d got %0d want %0d", edge_n, fifoCount, exp_count(edge_n));
         end
         if (bus.dataReady !== (exp_count(edge_n) < DEPTH)) begin
            n_fail++; $display("FAIL ovf_ready edge %0d got %b want %b", edge_n, bus.dataReady, exp_count(edge_n) < DEPTH);
         end
         if (int'(fifoCount) > max_cnt) max_cnt = int'(fifoCount);
         for (int f = base; f < starts.size() && f < base + 6; f++) begin
            rel = edge_n - starts[f];
            if (rel >= DIV && rel < 9 * DIV && rel % DIV == 5)
               rx[f - base][rel / DIV - 1] = txd;
         end
      end
      n_checks++;
      if (guard >= 2000) begin
         n_fail++; $display("FAIL ovf_timeout got %0d cycles want < 2000", guard);
      end
      n_checks++;
      if (max_cnt != DEPTH) begin
         n_fail++; $display("FAIL ovf_full got %0d want %0d", max_cnt, DEPTH);
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (rx[i] !== sent[i]) begin
            n_fail++; $display("FAIL ovf_order%0d got %h want %h", i, rx[i], sent[i]);
         end
      end
   endtask

   task automatic test_push_pop;
      int k;
      pend.push_back(8'h3C);
      pend.push_back(8'hC3);
      pend.push_back(8'h99);
      step(0);
      k = edge_n;
      while (edge_n < k + L) step(0);
      n_checks++;
      if (fifoCount !== 3'd2) begin
         n_fail++; $display("FAIL pp_before got %0d want 2", fifoCount);
      end
      pend.push_back(8'h5F);
      step(0);
      n_checks += 2;
      if (fifoCount !== 3'd2) begin
         n_fail++; $display("FAIL pp_same_edge got %0d want 2", fifoCount);
      end
      if (txd !== 1'b0) begin
         n_fail++; $display("FAIL pp_pop_start got %b want 0", txd);
      end
      while (exp_busy(edge_n) && edge_n < k + 6 * L) begin
         step(0);
         n_checks++;
         if (txd !== exp_txd(edge_n)) begin
            n_fail++; $display("FAIL pp_txd edge %0d got %b want %b", edge_n, txd, exp_txd(edge_n));
         end
      end
   endtask

   task automatic test_random;
      int sent;
      sent = 0;
      for (int c = 0; c < 1500 || pend.size() != 0 || exp_busy(edge_n); c++) begin
         if (c >= 4000) begin
            n_checks++;
            n_fail++; $display("FAIL rnd_timeout got %0d cycles want < 4000", c);
            break;
         end
         if (sent < 8 && c < 1500 && $urandom_range(0, 39) == 0) begin
            pend.push_back(8'($urandom));
            sent++;
         end
         step(0);
         n_checks += 3;
         if (txd !== exp_txd(edge_n)) begin
            n_fail++; $display("FAIL rnd_txd edge %0d got %b want %b", edge_n, txd, exp_txd(edge_n));
         end
         if (fifoCount !== 3'(exp_count(edge_n))) begin
            n_fail++; $display("FAIL rnd_count edge %0d got %0d want %0d", edge_n, fifoCount, exp_count(edge_n));
         end
         if (busy !== exp_busy(edge_n)) begin
            n_fail++; $display("FAIL rnd_busy edge %0d got %b want %b", edge_n, busy, exp_busy(edge_n));
         end
      end
   endtask

   task automatic test_reset_mid;
      int s;
      pend.push_back(8'h5A);
      pend.push_back(8'($urandom));
      pend.push_back(8'($urandom));
      step(0);
      s = starts[$];
      while (edge_n < s + 34) step(0);
      n_checks++;
      if (fifoCount !== 3'd2) begin
         n_fail++; $display("FAIL rst_queued got %0d want 2", fifoCount);
      end
      step(1);
      n_checks += 2;
      if (txd !== 1'b1) begin
         n_fail++; $display("FAIL rst_txd got %b want 1", txd);
      end
      if (fifoCount !== 3'd0) begin
         n_fail++; $display("FAIL rst_count got %0d want 0", fifoCount);
      end
      for (int c = 0; c < 300; c++) begin
         step(0);
         n_checks += 2;
         if (txd !== 1'b1) begin
            n_fail++; $display("FAIL rst_quiet_txd edge %0d got %b want 1", edge_n, txd);
         end
         if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_quiet_busy edge %0d got %b want 0", edge_n, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_overflow();
      test_push_pop();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
